// File: rtl/fetch_unit_pkg.sv
// Shared types for the instruction fetch stage: FSM states, buffer entry layout,
// and the word-alignment helper used for redirect targets.
package fetch_unit_pkg;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} fetch_state_e;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } fetch_entry_t;

   localparam int INSTR_BYTES = 4;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return addr & ~32'(INSTR_BYTES - 1);
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: DEPTH x fetch_entry_t, head visible combinationally from
// registered storage, synchronous flush, asynchronous reset.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            push,
   input  logic [$bits(fetch_entry_t)-1:0] push_data,
   input  logic                            pop,
   input  logic                            flush,
   output logic [$bits(fetch_entry_t)-1:0] head,
   output logic [$clog2(DEPTH):0]          count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [$bits(fetch_entry_t)-1:0] mem [DEPTH];
   logic [AW-1:0]                   wr_ptr, rd_ptr;

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= push_data;
            wr_ptr      <= wr_ptr + AW'(1);
         end
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, credit-limited imem requests, response buffering
// and redirect flush. Optional stall counter under FETCH_STALL_CNT_EN.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        clk_en,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_imem_req,
   input  logic        i_imem_gnt,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_rvalid,
   input  logic [31:0] i_imem_rdata,
`ifdef FETCH_STALL_CNT_EN
   output logic [31:0] o_stall_cnt,
`endif
   output logic [31:0] o_instruction,
   output logic [31:0] o_pc,
   output logic        o_valid,
   input  logic        i_ready
);

   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   fetch_state_e  state, state_nxt;
   logic [31:0]   pc, resp_pc;
   logic [CW-1:0] outstanding, out_nxt, drop, drop_nxt, fifo_count;
   logic [CW:0]   credit_used;
   logic          grant, rsp, push, pop, flush;
   fetch_entry_t  push_entry, head;

   // Requests are only issued while every possible response has a buffer slot.
   assign credit_used = {1'b0, outstanding} + {1'b0, fifo_count};
   assign o_imem_req  = clk_en && (state == FETCH) && !i_redirect &&
                        (credit_used < (CW+1)'(FIFO_DEPTH));
   assign o_imem_addr = pc;
   assign grant       = o_imem_req && i_imem_gnt;
   assign rsp         = clk_en && i_imem_rvalid;
   assign flush       = clk_en && i_redirect;
   assign push        = rsp && !i_redirect && (drop == '0);
   assign pop         = clk_en && o_valid && i_ready && !i_redirect;
   assign push_entry  = '{pc: resp_pc, instr: i_imem_rdata};

   always_comb begin
      out_nxt = outstanding;
      if (grant) out_nxt = out_nxt + CW'(1);
      if (rsp)   out_nxt = out_nxt - CW'(1);

      drop_nxt = drop;
      if (i_redirect)              drop_nxt = out_nxt;
      else if (rsp && drop != '0)  drop_nxt = drop - CW'(1);

      state_nxt = state;
      case (state)
         IDLE:    state_nxt = FETCH;
         FETCH:   if (i_redirect && out_nxt != '0) state_nxt = DRAIN;
         DRAIN:   if (drop_nxt == '0) state_nxt = FETCH;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pc          <= RESET_PC;
         resp_pc     <= RESET_PC;
         outstanding <= '0;
         drop        <= '0;
      end else if (clk_en) begin
         state       <= state_nxt;
         outstanding <= out_nxt;
         drop        <= drop_nxt;
         if (i_redirect) begin
            pc      <= word_align(i_redirect_pc);
            resp_pc <= word_align(i_redirect_pc);
         end else begin
            if (grant) pc      <= pc + 32'(INSTR_BYTES);
            if (push)  resp_pc <= resp_pc + 32'(INSTR_BYTES);
         end
      end
   end

   fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .count     (fifo_count)
   );

   assign o_valid       = (fifo_count != '0);
   assign o_pc          = head.pc;
   assign o_instruction = head.instr;

`ifdef FETCH_STALL_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                      o_stall_cnt <= '0;
      else if (clk_en && state != IDLE && !o_valid) o_stall_cnt <= o_stall_cnt + 32'd1;
   end
`else
   // Stall counter not present in this build.
`endif

   // A response with nothing outstanding means memory answered in its grant cycle.
   always_ff @(posedge clk) begin
      if (rsp) assert (outstanding != '0);
   end

endmodule
